// File: rtl/ds_agen_stage_pkg.sv
// Shared constants for the DS-form address-generation stage: functional-unit
// codes, FSM state encoding and DS xo sub-opcodes.
package ds_agen_stage_pkg;

  localparam logic [1:0] AluUnitCode    = 2'd0;
  localparam logic [1:0] LdStUnitCode   = 2'd1;
  localparam logic [1:0] BranchUnitCode = 2'd2;
  localparam logic [1:0] SysUnitCode    = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ_RA = 2'd1,
    CALC    = 2'd2,
    OUT     = 2'd3
  } agen_state_e;

  // Loads (opcode 58) and stores (opcode 62) share xo values.
  localparam logic [1:0] XO_LD   = 2'd0;
  localparam logic [1:0] XO_LDU  = 2'd1;
  localparam logic [1:0] XO_LWA  = 2'd2;
  localparam logic [1:0] XO_STD  = 2'd0;
  localparam logic [1:0] XO_STDU = 2'd1;
  localparam logic [1:0] XO_STQ  = 2'd2;

endpackage

// File: rtl/ds_ea_adder.sv
// Combinational DS effective-address adder: base + EXTS(imm || 0b00),
// wrapping modulo 2^addrWidth. Big-endian bit numbering throughout.
module ds_ea_adder #(
  parameter int immWidth  = 14,
  parameter int addrWidth = 64
) (
  input  logic [0:addrWidth-1] base_i,
  input  logic [0:immWidth-1]  imm_i,
  output logic [0:addrWidth-1] ea_o
);

  logic [0:addrWidth-1] disp;

  always_comb begin
    disp = {{(addrWidth-immWidth-2){imm_i[0]}}, imm_i, 2'b00};
    ea_o = base_i + disp;
  end

endmodule

// File: rtl/ds_agen_stage.sv
// DS-form EA stage: accept -> (RF read of RA) -> add -> hold result until ready_i;
// valid 2 cycles after accept (RA=0) or 2 after RF data. Optional DS_AGEN_ALIGN_CHECK_EN.
module ds_agen_stage
  import ds_agen_stage_pkg::*;
#(
  parameter int regWidth  = 5,
  parameter int immWidth  = 14,
  parameter int addrWidth = 64
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic [0:regWidth-1]  reg1_i,
  input  logic [0:regWidth-1]  reg2_i,
  input  logic                 reg2ValOrZero_i,
  input  logic [0:immWidth-1]  imm_i,
  input  logic [0:1]           functionalUnitCode_i,
  input  logic                 isStore_i,
  input  logic [0:1]           xo_i,
  output logic                 stall_o,
  output logic                 regReadEn_o,
  output logic [0:regWidth-1]  regReadAddr_o,
  input  logic [0:addrWidth-1] regReadData_i,
  input  logic                 regReadValid_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [0:addrWidth-1] ea_o,
  output logic [0:regWidth-1]  rt_o,
  output logic [0:regWidth-1]  ra_o,
  output logic                 update_o,
  output logic                 isStore_o,
  output logic [0:1]           xo_o,
  output logic                 invalidForm_o,
  output logic                 alignFault_o
);

  agen_state_e          state_q, state_d;
  logic [0:regWidth-1]  rt_q, rt_d, ra_q, ra_d;
  logic [0:immWidth-1]  imm_q, imm_d;
  logic [0:addrWidth-1] base_q, base_d, ea_q, ea_d, ea_sum;
  logic                 is_store_q, is_store_d;
  logic [0:1]           xo_q, xo_d;
  logic                 inv_q, inv_d;
  logic                 upd_form, inv_new;

  ds_ea_adder #(
    .immWidth  (immWidth),
    .addrWidth (addrWidth)
  ) u_ea_adder (
    .base_i (base_q),
    .imm_i  (imm_q),
    .ea_o   (ea_sum)
  );

  // Illegal-form decode on the incoming instruction; travels with the op.
  always_comb begin
    upd_form = (xo_i == XO_LDU);
    inv_new  = (upd_form && (reg2_i == '0))
            || (upd_form && !isStore_i && (reg2_i == reg1_i))
            || (xo_i == 2'd3);
  end

  always_comb begin
    state_d    = state_q;
    rt_d       = rt_q;
    ra_d       = ra_q;
    imm_d      = imm_q;
    base_d     = base_q;
    ea_d       = ea_q;
    is_store_d = is_store_q;
    xo_d       = xo_q;
    inv_d      = inv_q;
    case (state_q)
      IDLE: begin
        if (enable_i && (functionalUnitCode_i == LdStUnitCode)) begin
          rt_d       = reg1_i;
          ra_d       = reg2_i;
          imm_d      = imm_i;
          is_store_d = isStore_i;
          xo_d       = xo_i;
          inv_d      = inv_new;
          if (reg2ValOrZero_i && (reg2_i == '0)) begin
            base_d  = '0;
            state_d = CALC;
          end else begin
            state_d = READ_RA;
          end
        end
      end
      READ_RA: begin
        if (regReadValid_i) begin
          base_d  = regReadData_i;
          state_d = CALC;
        end
      end
      CALC: begin
        ea_d    = ea_sum;
        state_d = OUT;
      end
      OUT: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      rt_q       <= '0;
      ra_q       <= '0;
      imm_q      <= '0;
      base_q     <= '0;
      ea_q       <= '0;
      is_store_q <= 1'b0;
      xo_q       <= '0;
      inv_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rt_q       <= rt_d;
      ra_q       <= ra_d;
      imm_q      <= imm_d;
      base_q     <= base_d;
      ea_q       <= ea_d;
      is_store_q <= is_store_d;
      xo_q       <= xo_d;
      inv_q      <= inv_d;
    end
  end

`ifdef DS_AGEN_ALIGN_CHECK_EN
  logic align_q, align_d;

  // Natural alignment: 8 bytes for ld/ldu/std/stdu, 16 for stq, 4 for lwa.
  always_comb begin
    align_d = align_q;
    if (state_q == CALC) begin
      case (xo_q)
        XO_LD, XO_LDU: align_d = |ea_sum[addrWidth-3:addrWidth-1];
        XO_LWA:        align_d = is_store_q ? |ea_sum[addrWidth-4:addrWidth-1]
                                            : |ea_sum[addrWidth-2:addrWidth-1];
        default:       align_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) align_q <= 1'b0;
    else         align_q <= align_d;
  end

  assign alignFault_o = align_q;
`else
  assign alignFault_o = 1'b0;
`endif

  assign stall_o       = (state_q != IDLE);
  assign valid_o       = (state_q == OUT);
  assign regReadEn_o   = (state_q == READ_RA);
  assign regReadAddr_o = ra_q;
  assign ea_o          = ea_q;
  assign rt_o          = rt_q;
  assign ra_o          = ra_q;
  assign update_o      = (xo_q == XO_LDU);
  assign isStore_o     = is_store_q;
  assign xo_o          = xo_q;
  assign invalidForm_o = inv_q;

endmodule
